// File: rtl/color_zone_pkg.sv
// Shared types and geometry for the colour-zone detector: active frame
// size, zone width, zone identifiers, FSM states and counter width.
package color_zone_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int ZONE_W    = 160;
    localparam int NUM_ZONES = 4;
    localparam int CNT_W     = 17;

    typedef enum logic [2:0] {
        Z_RED    = 3'd0,
        Z_GREEN  = 3'd1,
        Z_BLUE   = 3'd2,
        Z_YELLOW = 3'd3,
        Z_NONE   = 3'd4
    } zone_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EVAL  = 2'd2
    } state_e;

    // Flag vector {yellow, blue, green, red}; NONE gives all zeros.
    function automatic logic [NUM_ZONES-1:0] zone_onehot(input zone_e z);
        logic [NUM_ZONES-1:0] oh;
        oh = '0;
        case (z)
            Z_RED:    oh = 4'b0001;
            Z_GREEN:  oh = 4'b0010;
            Z_BLUE:   oh = 4'b0100;
            Z_YELLOW: oh = 4'b1000;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/color_zone_detector_if.sv
// Camera pixel stream bundle: qualifier, raster position and colour.
// The camera side drives it (master); the detector only listens (slave).
interface color_zone_detector_if;

    logic       pix_valid;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;

    modport master (output pix_valid, x_pos, y_pos, R, G, B);
    modport slave  (input  pix_valid, x_pos, y_pos, R, G, B);

endinterface

// File: rtl/pixel_color_classifier.sv
// Stage 1 of the detector: decodes which zone a pixel falls in, checks it
// against that zone's colour and flags the first/last pixel of a frame.
module pixel_color_classifier
    import color_zone_pkg::*;
#(
    parameter logic [7:0] HI_THRESH = 8'd192,
    parameter logic [7:0] LO_THRESH = 8'd64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [1:0] zone,
    output logic       match,
    output logic       first,
    output logic       last
);

    localparam logic [9:0] X_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_LIM  = 10'(V_ACTIVE);
    localparam logic [9:0] X_Z1   = 10'(ZONE_W);
    localparam logic [9:0] X_Z2   = 10'(2 * ZONE_W);
    localparam logic [9:0] X_Z3   = 10'(3 * ZONE_W);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    logic       r_hi, r_lo, g_hi, g_lo, b_hi, b_lo;
    logic       in_active, colour_ok;
    logic [1:0] zone_d, zone_q;
    logic       match_d, match_q;
    logic       first_d, first_q;
    logic       last_d, last_q;

    // Zone decode plus colour test; off-screen pixels never match or mark frame edges
    always_comb begin
        r_hi      = (r >= HI_THRESH);
        r_lo      = (r < LO_THRESH);
        g_hi      = (g >= HI_THRESH);
        g_lo      = (g < LO_THRESH);
        b_hi      = (b >= HI_THRESH);
        b_lo      = (b < LO_THRESH);
        in_active = (x_pos < X_LIM) && (y_pos < Y_LIM);
        colour_ok = 1'b0;
        if (x_pos < X_Z1) begin
            zone_d = 2'd0;
        end else if (x_pos < X_Z2) begin
            zone_d = 2'd1;
        end else if (x_pos < X_Z3) begin
            zone_d = 2'd2;
        end else begin
            zone_d = 2'd3;
        end
        case (zone_d)
            2'd0:    colour_ok = r_hi && g_lo && b_lo;
            2'd1:    colour_ok = g_hi && r_lo && b_lo;
            2'd2:    colour_ok = b_hi && r_lo && g_lo;
            default: colour_ok = r_hi && g_hi && b_lo;
        endcase
        match_d = pix_valid && in_active && colour_ok;
        first_d = pix_valid && (x_pos == 10'd0) && (y_pos == 10'd0);
        last_d  = pix_valid && (x_pos == X_LAST) && (y_pos == Y_LAST);
    end

    // Stage-1 pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            zone_q  <= 2'd0;
            match_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            zone_q  <= zone_d;
            match_q <= match_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign zone  = zone_q;
    assign match = match_q;
    assign first = first_q;
    assign last  = last_q;

endmodule

// File: rtl/color_zone_detector.sv
// Per-frame colour-zone detector: counts matching pixels per zone, picks a
// candidate zone at frame end, debounces it over frames and drives the flags.
module color_zone_detector
    import color_zone_pkg::*;
#(
    parameter logic [7:0]       HI_THRESH     = 8'd192,
    parameter logic [7:0]       LO_THRESH     = 8'd64,
    parameter logic [CNT_W-1:0] COUNT_THRESH  = 17'd4000,
    parameter int               STABLE_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    color_zone_detector_if.slave pix_if,
    output logic                 red_flag,
    output logic                 green_flag,
    output logic                 blue_flag,
    output logic                 yellow_flag,
    output logic                 flags_valid
);

    localparam logic [7:0]       STABLE_LIM = 8'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0] s1_zone;
    logic       s1_match, s1_first, s1_last;

    logic [NUM_ZONES-1:0][CNT_W-1:0] cnt_d, cnt_q;
    logic [NUM_ZONES-1:0]            hit;
    logic                            restart;
    state_e                          state_d, state_q;
    zone_e                           new_cand, cand_d, cand_q;
    logic [7:0]                      stable_d, stable_q;
    logic [NUM_ZONES-1:0]            flags_d, flags_q;
    logic                            flags_valid_d, flags_valid_q;

    pixel_color_classifier #(
        .HI_THRESH (HI_THRESH),
        .LO_THRESH (LO_THRESH)
    ) u_classifier (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_if.pix_valid),
        .x_pos     (pix_if.x_pos),
        .y_pos     (pix_if.y_pos),
        .r         (pix_if.R),
        .g         (pix_if.G),
        .b         (pix_if.B),
        .zone      (s1_zone),
        .match     (s1_match),
        .first     (s1_first),
        .last      (s1_last)
    );

    // Zone counters: restart at frame start or evaluation (keeping a matching stage-1 pixel), else count and saturate
    always_comb begin
        restart = (state_q == S_EVAL) || s1_first;
        for (int i = 0; i < NUM_ZONES; i++) begin
            hit[i]   = s1_match && (s1_zone == 2'(i));
            cnt_d[i] = cnt_q[i];
            if (restart) begin
                cnt_d[i] = {{(CNT_W-1){1'b0}}, hit[i]};
            end else if ((state_q == S_ACCUM) && hit[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Candidate zone: lowest-numbered zone over threshold wins
    always_comb begin
        new_cand = Z_NONE;
        if (cnt_q[0] >= COUNT_THRESH) begin
            new_cand = Z_RED;
        end else if (cnt_q[1] >= COUNT_THRESH) begin
            new_cand = Z_GREEN;
        end else if (cnt_q[2] >= COUNT_THRESH) begin
            new_cand = Z_BLUE;
        end else if (cnt_q[3] >= COUNT_THRESH) begin
            new_cand = Z_YELLOW;
        end
    end

    // Frame FSM with the debounce and flag update done in the single EVAL cycle
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        stable_d      = stable_q;
        flags_d       = flags_q;
        flags_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s1_first) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (s1_last) state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = S_ACCUM;
                cand_d  = new_cand;
                if (new_cand == cand_q) begin
                    stable_d = (stable_q >= STABLE_LIM) ? STABLE_LIM : stable_q + 8'd1;
                end else begin
                    stable_d = 8'd1;
                end
                if (stable_d == STABLE_LIM) flags_d = zone_onehot(new_cand);
                flags_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cand_q        <= Z_NONE;
            stable_q      <= 8'd0;
            flags_q       <= '0;
            flags_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            stable_q      <= stable_d;
            flags_q       <= flags_d;
            flags_valid_q <= flags_valid_d;
        end
    end

    assign red_flag    = flags_q[0];
    assign green_flag  = flags_q[1];
    assign blue_flag   = flags_q[2];
    assign yellow_flag = flags_q[3];
    assign flags_valid = flags_valid_q;

endmodule

// File: tb/tb_color_zone_detector.sv
// Bench for color_zone_detector: three instances (debounce depth 1, 2, 3)
// share one pixel stream; each frame's expected flags come from a table.
`timescale 1ns/1ps
module tb_color_zone_detector;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_RED  = 4'b0001;
    localparam logic [3:0] F_GRN  = 4'b0010;
    localparam logic [3:0] F_BLU  = 4'b0100;
    localparam int         NUM_VECS = 11;

    typedef struct packed {
        int         n0;
        int         n1;
        int         n2;
        int         n3;
        logic [3:0] e1;
        logic [3:0] e2;
        logic [3:0] e3;
    } frame_vec_t;

    typedef struct packed {
        int         dut;
        int         cyc;
        logic [3:0] flags;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    wire  [3:0] flg [3];
    wire        fv [3];
    pulse_t     pq[$];
    frame_vec_t vecs [NUM_VECS];

    color_zone_detector_if pix_bus();

    always #5 clk = ~clk;

    // Cycle index used to measure output latency
    always @(posedge clk) cyc <= cyc + 1;

    color_zone_detector #(.STABLE_FRAMES(1)) dut_s1 (
        .clk(clk), .reset(reset), .pix_if(pix_bus),
        .red_flag(flg[0][0]), .green_flag(flg[0][1]), .blue_flag(flg[0][2]),
        .yellow_flag(flg[0][3]), .flags_valid(fv[0]));

    color_zone_detector #(.STABLE_FRAMES(2)) dut_s2 (
        .clk(clk), .reset(reset), .pix_if(pix_bus),
        .red_flag(flg[1][0]), .green_flag(flg[1][1]), .blue_flag(flg[1][2]),
        .yellow_flag(flg[1][3]), .flags_valid(fv[1]));

    color_zone_detector #(.STABLE_FRAMES(3)) dut_s3 (
        .clk(clk), .reset(reset), .pix_if(pix_bus),
        .red_flag(flg[2][0]), .green_flag(flg[2][1]), .blue_flag(flg[2][2]),
        .yellow_flag(flg[2][3]), .flags_valid(fv[2]));

    // Record every flags_valid pulse with its cycle and the flags beside it
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (fv[d] === 1'b1) pq.push_back(pulse_t'{dut: d, cyc: cyc, flags: flg[d]});
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string label, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", label, got, exp);
        end
    endtask

    task automatic drivePixel(input logic v, input int x, input int y,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        pix_bus.pix_valid = v;
        pix_bus.x_pos     = 10'(x);
        pix_bus.y_pos     = 10'(y);
        pix_bus.R         = r;
        pix_bus.G         = g;
        pix_bus.B         = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_bus.pix_valid = 1'b0;
        end
    endtask

    task automatic sendZone(input int z, input int n,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int i = 0; i < n; i++) drivePixel(1'b1, z * 160 + i % 160, 1 + i / 160, r, g, b);
    endtask

    // Pixels that must never count or mark a frame edge
    task automatic sendNoise();
        drivePixel(1'b1, 330,   5, 8'd0,   8'd0,   8'd191);
        drivePixel(1'b1, 331,   5, 8'd64,  8'd0,   8'd255);
        drivePixel(1'b1, 332,   5, 8'd0,   8'd64,  8'd255);
        drivePixel(1'b1, 100,   5, 8'd0,   8'd0,   8'd255);
        drivePixel(1'b1, 330, 480, 8'd0,   8'd0,   8'd255);
        drivePixel(1'b1, 700,   5, 8'd255, 8'd255, 8'd0);
        drivePixel(1'b0, 333,   5, 8'd0,   8'd0,   8'd255);
        drivePixel(1'b1,  10,   5, 8'd255, 8'd255, 8'd0);
        drivePixel(1'b1, 170,   5, 8'd255, 8'd0,   8'd0);
        drivePixel(1'b0, 639, 479, 8'd0,   8'd0,   8'd0);
        drivePixel(1'b0,   0,   0, 8'd255, 8'd0,   8'd0);
    endtask

    // One frame: (0,0), per-zone matching pixels at threshold-edge colours, noise, (639,479)
    task automatic applyStimulus(input frame_vec_t v, input logic first_red, output int last_cyc);
        drivePixel(1'b1, 0, 0, first_red ? 8'hFF : 8'h00, 8'h00, 8'h00);
        sendZone(0, v.n0, 8'd192, 8'd63,  8'd63);
        sendZone(1, v.n1, 8'd63,  8'd192, 8'd63);
        sendZone(2, v.n2, 8'd63,  8'd63,  8'd192);
        sendZone(3, v.n3, 8'd192, 8'd192, 8'd63);
        sendNoise();
        drivePixel(1'b1, 639, 479, 8'h00, 8'h00, 8'h00);
        last_cyc = cyc;
    endtask

    task automatic checkFramePulses(input string label, input int d, input int n_exp,
                                    input int cyc_a, input int fl_a, input int cyc_b, input int fl_b);
        pulse_t mine[$];
        foreach (pq[i]) if (pq[i].dut == d) mine.push_back(pq[i]);
        checkOutput($sformatf("%s S%0d pulse count", label, d + 1), mine.size(), n_exp);
        if (n_exp >= 1) begin
            if (mine.size() >= 1) begin
                checkOutput($sformatf("%s S%0d pulse0 cycle", label, d + 1), mine[0].cyc, cyc_a);
                checkOutput($sformatf("%s S%0d pulse0 flags", label, d + 1), int'(mine[0].flags), fl_a);
            end else begin
                checkOutput($sformatf("%s S%0d pulse0 missing", label, d + 1), -1, cyc_a);
            end
        end
        if (n_exp >= 2) begin
            if (mine.size() >= 2) begin
                checkOutput($sformatf("%s S%0d pulse1 cycle", label, d + 1), mine[1].cyc, cyc_b);
                checkOutput($sformatf("%s S%0d pulse1 flags", label, d + 1), int'(mine[1].flags), fl_b);
            end else begin
                checkOutput($sformatf("%s S%0d pulse1 missing", label, d + 1), -1, cyc_b);
            end
        end
    endtask

    function automatic int pickExp(input frame_vec_t v, input int d);
        if (d == 0) return int'(v.e1);
        if (d == 1) return int'(v.e2);
        return int'(v.e3);
    endfunction

    initial begin
        int         c_a, c_b;
        frame_vec_t fv_tmp;

        reset             = 1'b1;
        pix_bus.pix_valid = 1'b0;
        pix_bus.x_pos     = '0;
        pix_bus.y_pos     = '0;
        pix_bus.R         = '0;
        pix_bus.G         = '0;
        pix_bus.B         = '0;

        //             zone0 zone1 zone2 zone3  S1      S2      S3
        vecs[0]  = '{0,    0,    3999, 0,    F_NONE, F_NONE, F_NONE};
        vecs[1]  = '{0,    0,    4000, 0,    F_BLU,  F_NONE, F_NONE};
        vecs[2]  = '{4000, 0,    0,    4500, F_RED,  F_NONE, F_NONE};
        vecs[3]  = '{4000, 0,    0,    0,    F_RED,  F_RED,  F_NONE};
        vecs[4]  = '{0,    4000, 0,    0,    F_GRN,  F_RED,  F_NONE};
        vecs[5]  = '{0,    4000, 0,    0,    F_GRN,  F_GRN,  F_NONE};
        vecs[6]  = '{0,    4000, 0,    0,    F_GRN,  F_GRN,  F_GRN};
        vecs[7]  = '{0,    0,    0,    0,    F_NONE, F_GRN,  F_GRN};
        vecs[8]  = '{0,    4000, 0,    0,    F_GRN,  F_GRN,  F_GRN};
        vecs[9]  = '{0,    0,    0,    0,    F_NONE, F_GRN,  F_GRN};
        vecs[10] = '{0,    0,    0,    0,    F_NONE, F_NONE, F_GRN};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset S%0d flags", d + 1), int'(flg[d]), 0);
            checkOutput($sformatf("reset S%0d flags_valid", d + 1), int'(fv[d]), 0);
        end
        reset = 1'b0;
        idle(2);
        pq.delete();

        $display("[TB] table-driven frames");
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], 1'b0, c_a);
            idle(8);
            for (int d = 0; d < 3; d++) begin
                checkFramePulses($sformatf("frame%0d", i), d, 1, c_a + 3, pickExp(vecs[i], d), 0, 0);
            end
            pq.delete();
        end

        $display("[TB] reset in the middle of a frame");
        drivePixel(1'b1, 0, 0, 8'h00, 8'h00, 8'h00);
        sendZone(1, 50, 8'h00, 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drivePixel(1'b1, 170 + i, 60, 8'h00, 8'hFF, 8'h00);
            reset = 1'b1;
        end
        drivePixel(1'b1, 180, 60, 8'h00, 8'hFF, 8'h00);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("midreset S%0d flags", d + 1), int'(flg[d]), 0);
            checkOutput($sformatf("midreset S%0d flags_valid", d + 1), int'(fv[d]), 0);
        end
        sendZone(1, 100, 8'h00, 8'hFF, 8'h00);
        drivePixel(1'b1, 639, 479, 8'h00, 8'h00, 8'h00);
        idle(8);
        for (int d = 0; d < 3; d++) checkFramePulses("after reset", d, 0, 0, 0, 0, 0);
        pq.delete();

        $display("[TB] back-to-back frames, matching (0,0) right after last pixel");
        fv_tmp = '{0, 0, 0, 0, F_NONE, F_NONE, F_NONE};
        applyStimulus(fv_tmp, 1'b0, c_a);
        fv_tmp = '{3999, 0, 0, 0, F_NONE, F_NONE, F_NONE};
        applyStimulus(fv_tmp, 1'b1, c_b);
        idle(8);
        checkFramePulses("b2b", 0, 2, c_a + 3, int'(F_NONE), c_b + 3, int'(F_RED));
        checkFramePulses("b2b", 1, 2, c_a + 3, int'(F_NONE), c_b + 3, int'(F_NONE));
        checkFramePulses("b2b", 2, 2, c_a + 3, int'(F_NONE), c_b + 3, int'(F_NONE));
        pq.delete();

        $display("[TB] truncated frame restarted at (0,0)");
        drivePixel(1'b1, 0, 0, 8'h00, 8'h00, 8'h00);
        sendZone(0, 200, 8'hFF, 8'h00, 8'h00);
        drivePixel(1'b1, 5, 200, 8'h00, 8'h00, 8'h00);
        fv_tmp = '{3850, 0, 0, 0, F_NONE, F_NONE, F_NONE};
        applyStimulus(fv_tmp, 1'b0, c_a);
        idle(8);
        for (int d = 0; d < 3; d++) checkFramePulses("truncated", d, 1, c_a + 3, int'(F_NONE), 0, 0);
        pq.delete();

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
